// File: rtl/free_list_if.sv
// Dispatch/retire-side bundle for the free_list block: tag allocation, tag release and rollback.
// The master modport belongs to the pipeline (dispatch + ROB), the slave modport to free_list.
interface free_list_if #(
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32
);
    localparam int DEPTH  = NUM_PREG - NUM_AREG;
    localparam int PREG_W = $clog2(NUM_PREG);
    localparam int PTR_W  = $clog2(DEPTH);

    // Allocation is a valid/ready pair in disguise: !empty is "ready", dequeue_en is "valid";
    // a transfer happens only on an edge where both hold and undo is low. Release has no back-pressure.
    logic              dequeue_en;
    logic [PREG_W-1:0] dest_tag;
    logic              empty;
    logic              enqueue_en;
    logic [PREG_W-1:0] enqueue_pr;
    logic              undo;
    logic [PTR_W:0]    undo_head;
    logic [PTR_W:0]    head_ptr;
    logic [PTR_W:0]    free_count;

    modport master (
        output dequeue_en,
        output enqueue_en,
        output enqueue_pr,
        output undo,
        output undo_head,
        input  dest_tag,
        input  empty,
        input  head_ptr,
        input  free_count
    );

    modport slave (
        input  dequeue_en,
        input  enqueue_en,
        input  enqueue_pr,
        input  undo,
        input  undo_head,
        output dest_tag,
        output empty,
        output head_ptr,
        output free_count
    );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags with checkpointed-head rollback.
// Optional same-cycle forwarding of a released tag into an empty list: FREE_LIST_BYPASS_EN.
module free_list #(
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32
) (
    input  logic       clock,
    input  logic       reset,
    free_list_if.slave fl
);
    localparam int DEPTH  = NUM_PREG - NUM_AREG;   // must be a power of two
    localparam int PREG_W = $clog2(NUM_PREG);
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [PREG_W-1:0] ZERO_REG = '0;
    localparam logic [PTR_W:0]    DEPTH_P  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    PTR_ONE  = (PTR_W + 1)'(1);

    logic [PREG_W-1:0] r_buffer [DEPTH];
    logic [PTR_W:0]    r_head;
    logic [PTR_W:0]    r_tail;

    logic [PTR_W:0]    w_count;
    logic [PTR_W-1:0]  w_head_idx;
    logic [PTR_W-1:0]  w_tail_idx;
    logic              w_empty_reg;
    logic              w_full;
    logic              w_enq_valid;
    logic              w_bypass;
    logic              w_bypass_take;
    logic              w_do_deq;
    logic              w_do_enq;

    // The wrap bit keeps full (difference == DEPTH) distinct from empty (difference == 0).
    assign w_count     = r_tail - r_head;
    assign w_head_idx  = r_head[PTR_W-1:0];
    assign w_tail_idx  = r_tail[PTR_W-1:0];
    assign w_empty_reg = (w_count == '0);
    assign w_full      = (w_count == DEPTH_P);

    // A released x0 carries no physical register and never enters the list.
    assign w_enq_valid = fl.enqueue_en && (fl.enqueue_pr != ZERO_REG);

`ifdef FREE_LIST_BYPASS_EN
    assign w_bypass = w_empty_reg && w_enq_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // On a bypass hand-off the tag goes straight to dispatch and never touches the buffer.
    assign w_bypass_take = w_bypass && fl.dequeue_en && !fl.undo;
    assign w_do_deq      = fl.dequeue_en && !w_empty_reg && !fl.undo;
    assign w_do_enq      = w_enq_valid && !w_full && !w_bypass_take;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= DEPTH_P;
        end else begin
            // Undo wins over dequeue; the retiring enqueue is older than the branch and still lands.
            if (fl.undo) begin
                r_head <= fl.undo_head;
            end else if (w_do_deq) begin
                r_head <= r_head + PTR_ONE;
            end
            if (w_do_enq) begin
                r_tail <= r_tail + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buffer[i] <= PREG_W'(NUM_AREG + i);
            end
        end else if (w_do_enq) begin
            r_buffer[w_tail_idx] <= fl.enqueue_pr;
        end
    end

    always_comb begin
        fl.dest_tag = ZERO_REG;
        if (w_bypass) begin
            fl.dest_tag = fl.enqueue_pr;
        end else if (!w_empty_reg) begin
            fl.dest_tag = r_buffer[w_head_idx];
        end
    end

    assign fl.empty      = w_empty_reg && !w_bypass;
    assign fl.head_ptr   = r_head;
    assign fl.free_count = w_count;

`ifndef SYNTHESIS
    logic [PTR_W:0] w_undo_dist;
    assign w_undo_dist = r_tail - fl.undo_head;

    a_count_range: assert property (@(posedge clock) disable iff (reset)
        w_count <= DEPTH_P);
    a_no_enq_full: assert property (@(posedge clock) disable iff (reset)
        !(w_enq_valid && w_full));
    // A checkpoint can be at most DEPTH entries behind the tail, never ahead of it.
    a_undo_range: assert property (@(posedge clock) disable iff (reset)
        fl.undo |-> (w_undo_dist <= DEPTH_P));
`endif
endmodule
